fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Schedules the single write port of the frame buffer between two pixel-write requesters and a built-in full-screen clear sequencer. It sits between the GPU drawing units (rasterizer on port 0, blitter on port 1) and the frame buffer's write interface, all in the `gpu_clk` domain. It guarantees at most one write per cycle, fair round-robin sharing between requesters, and exclusive port ownership during a clear.

## Interface

Parameters:
- `PIXEL_W`, 4: pixel colour width.
- `ADDR_W`, 17: pixel address width. Must cover `NUM_PIXELS`.
- `NUM_PIXELS`, 76800: frame size (320x240). Valid addresses are 0..`NUM_PIXELS`-1.

Ports:
- `gpu_clk`  in  1  clock; one clock for the whole block.
- `gpu_rst_n`  in  1  reset, asynchronous, active-low.
- `clear_start`  in  1  single-cycle request to fill the whole frame with `clear_color`.
- `clear_color`  in  `PIXEL_W`  fill colour, sampled in the `clear_start` cycle.
- `clear_busy`  out  1  high while the clear sequencer owns the port.
- `clear_done`  out  1  one-cycle pulse when a clear completes.
- `req0_valid` / `req1_valid`  in  1  write request valid.
- `req0_ready` / `req1_ready`  out  1  write accepted this cycle.
- `req0_addr` / `req1_addr`  in  `ADDR_W`  target pixel address.
- `req0_pixel` / `req1_pixel`  in  `PIXEL_W`  pixel value.
- `fb_we`  out  1  frame buffer write enable (registered).
- `fb_addr`  out  `ADDR_W`  frame buffer write address (registered).
- `fb_pixel`  out  `PIXEL_W`  frame buffer write data (registered).

## Operation

- FSM states:
  - ARB: reset state.
  - CLEAR.
- ARB behaviour:
  - `readyN = validN && granted && !clear_start`.
  - Only one request is granted per cycle.
  - A transfer occurs when valid and ready are both high.
  - A requester must hold valid, addr and pixel stable until ready.
- Round-robin arbitration:
  - `last_grant` register, reset to 1, so port 0 wins the first contention.
  - With both ports valid, the port other than `last_grant` wins.
  - With a single port valid, that port wins.
  - `last_grant` updates on every transfer.
- Out-of-range address (>= `NUM_PIXELS`):
  - The request is still accepted (ready high).
  - No write is issued (`fb_we` stays 0).
- ARB → CLEAR:
  - Occurs on `clear_start` in ARB.
  - `clear_color` is latched and the clear counter is reset to 0.
  - No requester is granted in that cycle.
- CLEAR behaviour:
  - Both readies are 0.
  - Each cycle issues one write (counter address, latched colour) and increments the counter.
  - After issuing address `NUM_PIXELS`-1, the FSM returns to ARB.
- `clear_start` while in CLEAR is ignored; there is no restart and no queuing.
- Reset values: `fb_we`=0, `fb_addr`=0, `fb_pixel`=0, `clear_busy`=0, `clear_done`=0, readies 0, state ARB, counter 0.
- Reset mid-clear abandons the clear with no `clear_done` pulse. Partial frame contents are left as written.

## Timing

- Requester latency: a transfer in cycle N appears on `fb_we`/`fb_addr`/`fb_pixel` in cycle N+1.
- Clear timing, with `clear_start` in cycle N:
  - `clear_busy` is high in cycles N+1..N+`NUM_PIXELS`.
  - Address k is visible on the outputs at cycle N+2+k.
  - The last write (address 76799) and the `clear_done` pulse both appear in cycle N+1+`NUM_PIXELS`.
  - Requests can be accepted again from that cycle on.
- Throughput: one write per cycle, sustained, in both states.
- `fb_we` deasserts in the cycle after a cycle with no transfer.

## Configuration

- `FB_SCHED_OOR_COUNT_EN` defined:
  - Adds output `oor_count` (16 bits).
  - The counter saturates at 0xFFFF.
  - It increments on each accepted out-of-range request and resets to 0.
- Without the macro: no port and no counter. Out-of-range requests are silently dropped.

## Structure

- Shared package `fb_pkg` holds:
  - `PIXEL_W`, `ADDR_W`, `NUM_PIXELS` constants.
  - The `fb_sched_state_t` enum (ARB, CLEAR).
  - The `fb_write_t` struct (we, addr, pixel), shared with the frame buffer.
- Sub-module `fb_rr_arbiter`:
  - 2-way round-robin grant logic with the `last_grant` register.
  - Inputs: valids and an advance enable. Output: one-hot grant.

## Test plan

- Reset then single write:
  - Stimulus: `req0_valid`=1, addr 5, pixel 0xA.
  - Response: `req0_ready`=1 that cycle; next cycle `fb_we`=1, `fb_addr`=5, `fb_pixel`=0xA; `req1_ready`=0.
- Contention for 4 cycles, both ports valid:
  - Stimulus: port 0 writes addr 1, port 1 writes addr 2 (pixels 0x1/0x2), port 0 holding valid.
  - Response: grants alternate 0,1,0,1; `fb_addr` sequence 1,2,1,2.
- Full clear with `clear_color`=0x7:
  - Stimulus: `req1_valid` held high throughout.
  - Response:
    - 76800 consecutive writes, addresses 0..76799, all with pixel 0x7.
    - `req1_ready`=0 throughout.
    - `clear_done` pulses exactly once, in the same cycle as the address 76799 write.
    - `req1` is granted that cycle.
- Out-of-range request:
  - Stimulus: addr 76800 on port 0.
  - Response: `req0_ready`=1; `fb_we` stays 0; with `FB_SCHED_OOR_COUNT_EN`, `oor_count`=1.
- Clear interrupted:
  - Stimulus: `clear_start` again at counter 100 (ignored), then `gpu_rst_n` low at counter 200.
  - Response: all outputs 0 immediately; no `clear_done`; state ARB after release.
- Clear start with a pending request:
  - Stimulus: `clear_start` and `req0_valid` in the same cycle.
  - Response: `req0_ready`=0; the first `fb_we` is the clear write to address 0, two cycles later.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame buffer constants and types used by the write scheduler and the frame buffer.
package fb_pkg;

  localparam int PIXEL_W    = 4;
  localparam int ADDR_W     = 17;
  localparam int NUM_PIXELS = 76800;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_sched_state_t;

  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [PIXEL_W-1:0] pixel;
  } fb_write_t;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Two-way round-robin grant; last_grant resets to port 1 so port 0 wins the first contention.
module fb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    if (valid == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
    // grant is one-hot whenever a transfer happens, so bit 1 names the winner
    last_grant_d = advance ? grant[1] : last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame buffer write-port scheduler: round-robin between two requesters plus a full-screen clear.
// Optional FB_SCHED_OOR_COUNT_EN adds a saturating out-of-range request counter output.
module fb_write_scheduler #(
  parameter int PIXEL_W    = fb_pkg::PIXEL_W,
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int NUM_PIXELS = fb_pkg::NUM_PIXELS
) (
  input  logic               gpu_clk,
  input  logic               gpu_rst_n,
  input  logic               clear_start,
  input  logic [PIXEL_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [PIXEL_W-1:0] req0_pixel,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [PIXEL_W-1:0] req1_pixel,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [PIXEL_W-1:0] fb_pixel
`ifdef FB_SCHED_OOR_COUNT_EN
  ,
  output logic [15:0]        oor_count
`endif
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  fb_sched_state_t    state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [PIXEL_W-1:0] color_q, color_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic               done_q, done_d;

  logic [1:0]         valid, grant, xfer;
  logic               arb_en;
  logic [ADDR_W-1:0]  sel_addr;
  logic [PIXEL_W-1:0] sel_pixel;
  logic               sel_oor;

  assign valid = {req1_valid, req0_valid};

  fb_rr_arbiter u_arb (
    .clk     (gpu_clk),
    .rst_n   (gpu_rst_n),
    .valid   (valid),
    .advance (|xfer),
    .grant   (grant)
  );

  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (clear_start) state_d = ST_CLEAR;
      ST_CLEAR: if (cnt_q == LAST_ADDR) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  // clear_start steals the cycle it arrives in, so no requester is granted then
  always_comb begin
    arb_en     = (state_q == ST_ARB) && !clear_start;
    xfer       = arb_en ? (valid & grant) : 2'b00;
    clear_busy = (state_q == ST_CLEAR);
  end

  assign req0_ready = xfer[0];
  assign req1_ready = xfer[1];

  always_comb begin
    sel_addr  = xfer[1] ? req1_addr  : req0_addr;
    sel_pixel = xfer[1] ? req1_pixel : req0_pixel;
    sel_oor   = (sel_addr > LAST_ADDR);
    cnt_d     = cnt_q;
    color_d   = color_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    pixel_d   = pixel_q;
    done_d    = 1'b0;
    if (state_q == ST_CLEAR) begin
      we_d    = 1'b1;
      addr_d  = cnt_q;
      pixel_d = color_q;
      cnt_d   = cnt_q + ADDR_W'(1);
      done_d  = (cnt_q == LAST_ADDR);
    end else if (clear_start) begin
      cnt_d   = '0;
      color_d = clear_color;
    end else if ((|xfer) && !sel_oor) begin
      we_d    = 1'b1;
      addr_d  = sel_addr;
      pixel_d = sel_pixel;
    end
  end

  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      cnt_q   <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      pixel_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      color_q <= color_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      pixel_q <= pixel_d;
      done_q  <= done_d;
    end
  end

  assign fb_we      = we_q;
  assign fb_addr    = addr_q;
  assign fb_pixel   = pixel_q;
  assign clear_done = done_q;

`ifdef FB_SCHED_OOR_COUNT_EN
  logic [15:0] oor_q, oor_d;

  always_comb begin
    oor_d = oor_q;
    if ((|xfer) && sel_oor && (oor_q != 16'hFFFF)) oor_d = oor_q + 16'd1;
  end

  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      oor_q <= '0;
    end else begin
      oor_q <= oor_d;
    end
  end

  assign oor_count = oor_q;
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: directed steps plus random requesters vs. a cycle-level reference model.
module tb_fb_write_scheduler;

  localparam int PIXEL_W    = 4;
  localparam int ADDR_W     = 17;
  localparam int NUM_PIXELS = 76800;

  logic               gpu_clk;
  logic               gpu_rst_n;
  logic               clear_start;
  logic [PIXEL_W-1:0] clear_color;
  logic               clear_busy;
  logic               clear_done;
  logic               req0_valid, req0_ready;
  logic [ADDR_W-1:0]  req0_addr;
  logic [PIXEL_W-1:0] req0_pixel;
  logic               req1_valid, req1_ready;
  logic [ADDR_W-1:0]  req1_addr;
  logic [PIXEL_W-1:0] req1_pixel;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [PIXEL_W-1:0] fb_pixel;
`ifdef FB_SCHED_OOR_COUNT_EN
  logic [15:0]        oor_count;
`endif

  fb_write_scheduler #(
    .PIXEL_W    (PIXEL_W),
    .ADDR_W     (ADDR_W),
    .NUM_PIXELS (NUM_PIXELS)
  ) dut (
    .gpu_clk     (gpu_clk),
    .gpu_rst_n   (gpu_rst_n),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_addr   (req0_addr),
    .req0_pixel  (req0_pixel),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_addr   (req1_addr),
    .req1_pixel  (req1_pixel),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_pixel    (fb_pixel)
`ifdef FB_SCHED_OOR_COUNT_EN
    ,
    .oor_count   (oor_count)
`endif
  );

  initial gpu_clk = 1'b0;
  always #5 gpu_clk = ~gpu_clk;

  int checks = 0;
  int failures = 0;
  bit quiet = 0;
  int quiet_bad = 0;

  // reference model state
  int  m_last;
  bit  m_in_clear;
  int  m_cnt;
  int  m_color;
  int  m_oor;
  int  m_win;
  bit  e_we;
  bit  e_done;
  int  e_addr;
  int  e_pix;
  logic [1:0] g_obs;

  bit pend [2];
  int pa   [2];
  int pp   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    if (quiet) begin
      if (obs !== exp) quiet_bad++;
    end else begin
      checks++;
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_in_clear = 0; m_cnt = 0; m_color = 0; m_oor = 0;
    e_we = 0; e_done = 0; e_addr = 0; e_pix = 0; m_win = -1;
  endtask

  // Called at posedge+1 with inputs already driven; checks at posedge+2, then advances one cycle.
  task automatic step();
    int win;
    int a;
    int p;
    #1;
    win = -1;
    if (!m_in_clear && !clear_start) begin
      if (req0_valid && req1_valid) win = (m_last == 1) ? 0 : 1;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    m_win = win;
    g_obs = {req1_ready, req0_ready};
    chk("ready0", req0_ready, win == 0);
    chk("ready1", req1_ready, win == 1);
    chk("fb_we", fb_we, e_we);
    if (e_we) begin
      chk("fb_addr", fb_addr, e_addr);
      chk("fb_pixel", fb_pixel, e_pix);
    end
    chk("clear_done", clear_done, e_done);
    chk("clear_busy", clear_busy, m_in_clear);
`ifdef FB_SCHED_OOR_COUNT_EN
    chk("oor_count", oor_count, m_oor);
`endif
    e_we = 0;
    e_done = 0;
    if (m_in_clear) begin
      e_we = 1; e_addr = m_cnt; e_pix = m_color;
      if (m_cnt == NUM_PIXELS - 1) begin
        m_in_clear = 0;
        e_done = 1;
      end else begin
        m_cnt++;
      end
    end else if (clear_start) begin
      m_in_clear = 1; m_cnt = 0; m_color = int'(clear_color);
    end else if (win >= 0) begin
      m_last = win;
      a = (win == 1) ? int'(req1_addr)  : int'(req0_addr);
      p = (win == 1) ? int'(req1_pixel) : int'(req0_pixel);
      if (a < NUM_PIXELS) begin
        e_we = 1; e_addr = a; e_pix = p;
      end else if (m_oor < 65535) begin
        m_oor++;
      end
    end
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0]; req0_addr = ADDR_W'(pa[0]); req0_pixel = PIXEL_W'(pp[0]);
    req1_valid = pend[1]; req1_addr = ADDR_W'(pa[1]); req1_pixel = PIXEL_W'(pp[1]);
  endtask

  initial begin
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    gpu_rst_n = 1'b0; clear_start = 1'b0; clear_color = '0;
    req0_valid = 1'b0; req0_addr = '0; req0_pixel = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_pixel = '0;
    model_reset();

    // reset state
    repeat (3) @(posedge gpu_clk);
    #2;
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_pixel", fb_pixel, 0);
    chk("rst_clear_busy", clear_busy, 1'b0);
    chk("rst_clear_done", clear_done, 1'b0);
    chk("rst_readies", {req1_ready, req0_ready}, 2'b00);
    gpu_rst_n = 1'b1;
    @(posedge gpu_clk);
    #1;

    // single write from port 0
    req0_valid = 1; req0_addr = 5; req0_pixel = 4'hA;
    step();
    chk("single_grant", g_obs, 2'b01);
    req0_valid = 0;
    step();

    // port 1 alone so that port 0 holds priority going into contention
    req1_valid = 1; req1_addr = 9; req1_pixel = 4'h3;
    step();
    req1_valid = 0;
    step();

    // contention: grants must alternate 0,1,0,1
    req0_valid = 1; req0_addr = 1; req0_pixel = 4'h1;
    req1_valid = 1; req1_addr = 2; req1_pixel = 4'h2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("contention_grant", g_obs, exp_seq[i]);
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // random requesters obeying the hold-until-ready rule
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r] = 1;
          pa[r] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NUM_PIXELS, (1 << ADDR_W) - 1))
                                              : int'($urandom_range(0, NUM_PIXELS - 1));
          pp[r] = int'($urandom_range(0, (1 << PIXEL_W) - 1));
        end
      end
      drive_reqs();
      step();
      if (m_win >= 0) pend[m_win] = 0;
    end
    for (int c = 0; c < 10 && (pend[0] || pend[1]); c++) begin
      drive_reqs();
      step();
      if (m_win >= 0) pend[m_win] = 0;
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // out-of-range request: accepted, nothing written
    req0_valid = 1; req0_addr = ADDR_W'(NUM_PIXELS); req0_pixel = 4'hF;
    step();
    chk("oor_grant", g_obs, 2'b01);
    req0_valid = 0;
    step();
    chk("oor_no_write", fb_we, 1'b0);

    // full clear, started together with a pending port 0 request; port 1 held valid throughout
    clear_start = 1; clear_color = 4'h7;
    req0_valid = 1; req0_addr = 20; req0_pixel = 4'h3;
    req1_valid = 1; req1_addr = 30; req1_pixel = 4'h4;
    step();
    chk("clear_start_readies", g_obs, 2'b00);
    clear_start = 0;
    step();
    step();
    quiet = 1;
    while (m_in_clear) step();
    quiet = 0;
    chk("clear_body_mismatches", quiet_bad, 0);
    step();
    chk("clear_done_cycle_grant", g_obs, 2'b10);
    req1_valid = 0;
    step();
    req0_valid = 0;
    step();

    // interrupted clear: restart attempt ignored, then reset mid-clear
    clear_start = 1; clear_color = 4'h5;
    step();
    clear_start = 0;
    while (m_cnt != 100) step();
    clear_start = 1; clear_color = 4'h9;
    step();
    clear_start = 0;
    while (m_cnt != 200) step();
    gpu_rst_n = 1'b0;
    #1;
    chk("midrst_fb_we", fb_we, 1'b0);
    chk("midrst_fb_addr", fb_addr, 0);
    chk("midrst_fb_pixel", fb_pixel, 0);
    chk("midrst_clear_busy", clear_busy, 1'b0);
    chk("midrst_clear_done", clear_done, 1'b0);
    chk("midrst_readies", {req1_ready, req0_ready}, 2'b00);
    repeat (2) @(posedge gpu_clk);
    #3;
    gpu_rst_n = 1'b1;
    model_reset();
    @(posedge gpu_clk);
    #1;
    repeat (3) step();
    req1_valid = 1; req1_addr = 100; req1_pixel = 4'hC;
    step();
    chk("post_rst_grant", g_obs, 2'b10);
    req1_valid = 0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
